// File: rtl/alu_add_pipe.sv
// Segmented carry-pipelined adder/subtractor with a valid/ready stream interface.
// Each stage adds one SEG-wide slice; unconsumed operand slices ride along in skew registers.
module alu_add_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic             OutValid,
    input  logic             OutReady
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    // Handshake: an input is taken on a rising edge when InValid & InReady;
    // a result leaves when OutValid & OutReady; the whole pipe freezes on
    // OutValid & ~OutReady, and InReady is the combinational inverse of that.

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] vld_q, vld_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    // Stage inputs: stage 0 sees the ports, stage k sees rank k-1.
    logic [WIDTH-1:0] pa [STAGES];
    logic [WIDTH-1:0] pb [STAGES];
    logic [WIDTH-1:0] ps [STAGES];
    logic [STAGES-1:0] pc, pv, en;
    logic [SEG:0]      seg_sum;
    logic              stall, advance;

    always_comb begin
        stall   = vld_q[LAST] & ~OutReady;
        advance = ~stall;

        pa[0] = A;
        pb[0] = Sub ? ~B : B;
        ps[0] = '0;
        pc    = '0;
        pv    = '0;
        pc[0] = Sub;
        pv[0] = InValid;
        for (int k = 1; k < STAGES; k++) begin
            pa[k] = a_q[k-1];
            pb[k] = b_q[k-1];
            ps[k] = sum_q[k-1];
            pc[k] = carry_q[k-1];
            pv[k] = vld_q[k-1];
        end

        vld_d   = advance ? pv : vld_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        en      = '0;
        seg_sum = '0;

        // Data ranks only load real operations, so bubbles leave the
        // output values untouched while OutValid is low.
        for (int k = 0; k < STAGES; k++) begin
            en[k]   = advance & pv[k];
            seg_sum = {1'b0, pa[k][k*SEG +: SEG]} + {1'b0, pb[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, pc[k]};
            if (en[k]) begin
                a_d[k]                 = pa[k];
                b_d[k]                 = pb[k];
                sum_d[k]               = ps[k];
                sum_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
                carry_d[k]             = seg_sum[SEG];
            end
        end

        if (en[LAST]) begin
            ovf_d  = (pa[LAST][WIDTH-1] == pb[LAST][WIDTH-1]) &
                     (sum_d[LAST][WIDTH-1] != pa[LAST][WIDTH-1]);
            zero_d = ~|sum_d[LAST];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            carry_q <= '0;
            vld_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign InReady  = advance;
    assign Result   = sum_q[LAST];
    assign Carry    = carry_q[LAST];
    assign Overflow = ovf_q;
    assign Zero     = zero_q;
    assign OutValid = vld_q[LAST];

endmodule

// File: tb/tb_alu_add_pipe.sv
// Bench for alu_add_pipe: a 32/8 four-stage instance and a 16/16 single-stage instance.
module tb_alu_add_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a32 = '0, b32 = '0, res32;
    logic        sub32 = 1'b0, iv32 = 1'b0, ir32, c32, o32, z32, ov32, or32 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0, res16;
    logic        sub16 = 1'b0, iv16 = 1'b0, ir16, c16, o16, z16, ov16, or16 = 1'b1;

    alu_add_pipe #(.WIDTH(32), .SEG(8)) dut32 (
        .Clk(clk), .Rst(rst), .A(a32), .B(b32), .Sub(sub32), .InValid(iv32),
        .InReady(ir32), .Result(res32), .Carry(c32), .Overflow(o32), .Zero(z32),
        .OutValid(ov32), .OutReady(or32)
    );

    alu_add_pipe #(.WIDTH(16), .SEG(16)) dut16 (
        .Clk(clk), .Rst(rst), .A(a16), .B(b16), .Sub(sub16), .InValid(iv16),
        .InReady(ir16), .Result(res16), .Carry(c16), .Overflow(o16), .Zero(z16),
        .OutValid(ov16), .OutReady(or16)
    );

    int checks = 0;
    int failures = 0;

    // Expected entries: {result[31:0], carry, overflow, zero}
    logic [34:0] exp32_q[$];
    logic [34:0] exp16_q[$];
    logic [34:0] e32, e16;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] bx;
        logic [32:0] sum;
        logic        v;
        bx  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {32'd0, s};
        v   = (a[31] == bx[31]) && (sum[31] != a[31]);
        return {sum[31:0], sum[32], v, (sum[31:0] == 32'd0)};
    endfunction

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [34:0] exp);
        int g;
        g = 0;
        @(negedge clk);
        a32 = a; b32 = b; sub32 = s; iv32 = 1'b1;
        #1;
        while (!ir32 && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("send32_ready_wait", (g < 50), 1);
        exp32_q.push_back(exp);
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom_range(0, 1));
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [34:0] exp);
        @(negedge clk);
        a16 = a; b16 = b; sub16 = s; iv16 = 1'b1;
        #1;
        chk("send16_ready", ir16, 1);
        exp16_q.push_back(exp);
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
    endtask

    // Counts edges from the accepting edge (1) until OutValid appears.
    task automatic latency32(input int exp_n);
        int n;
        n = 1;
        while (!ov32 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency32", n, exp_n);
    endtask

    task automatic drain;
        int g;
        g = 0;
        while ((exp32_q.size() != 0 || exp16_q.size() != 0) && g < 100) begin
            @(negedge clk);
            #3;
            g++;
        end
        chk("drain_pending", exp32_q.size() + exp16_q.size(), 0);
    endtask

    // Scoreboard: a transfer seen before the edge is compared with the oldest entry.
    always @(negedge clk) begin
        #2;
        if (!rst && ov32 && or32) begin
            chk("out32_has_expected", (exp32_q.size() != 0), 1);
            if (exp32_q.size() != 0) begin
                e32 = exp32_q.pop_front();
                chk("out32", {res32, c32, o32, z32}, e32);
            end
        end
        if (!rst && ov16 && or16) begin
            chk("out16_has_expected", (exp16_q.size() != 0), 1);
            if (exp16_q.size() != 0) begin
                e16 = exp16_q.pop_front();
                chk("out16", {16'h0000, res16, c16, o16, z16}, e16);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic        seen;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_result", res32, 0);
        chk("rst_flags", {c32, o32, z32, ov32}, 4'b0000);
        chk("rst_in_ready", ir32, 1);
        chk("rst16_out", {res16, c16, o16, z16, ov16}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Carry across a segment boundary, first op after reset
        send32(32'h0000_00FF, 32'h0000_0001, 1'b0, {32'h0000_0100, 1'b0, 1'b0, 1'b0});
        latency32(4);
        drain();

        // Signed overflow then zero difference, back to back
        send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
        send32(32'h0000_0005, 32'h0000_0005, 1'b1, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
        drain();
        @(negedge clk);
        #1;
        chk("idle_out_valid", ov32, 0);
        chk("hold_result", {res32, c32, o32, z32}, {32'h0, 1'b1, 1'b0, 1'b1});

        // Borrow
        send32(32'h0000_0000, 32'h0000_0001, 1'b1, {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
        drain();

        // Single-stage instance
        send16(16'hFFFF, 16'h0001, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
        chk("latency16_ov", ov16, 1);
        drain();

        // Random stream with a 3-cycle downstream stall in the middle
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                @(negedge clk);
                or32 = 1'b0;
                fork
                    begin
                        for (int j = 0; j < 3; j++) begin
                            #1;
                            chk("stall_in_ready", ir32, 0);
                            chk("stall_out_valid", ov32, 1);
                            @(negedge clk);
                        end
                        or32 = 1'b1;
                    end
                join_none
            end
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            send32(ra, rb, rs, model(ra, rb, rs));
        end
        drain();

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            send32(ra, rb, 1'b0, model(ra, rb, 1'b0));
        end
        @(negedge clk);
        rst = 1'b1;
        exp32_q.delete();
        #1;
        chk("midrst_out_valid", ov32, 0);
        chk("midrst_outputs", {res32, c32, o32, z32}, 0);
        chk("midrst_in_ready", ir32, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (ov32) seen = 1'b1;
        end
        chk("no_ghost_output", seen, 0);
        send32(32'h1234_5678, 32'h1111_1111, 1'b1, {32'h0123_4567, 1'b1, 1'b0, 1'b0});
        latency32(4);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
